// File: rtl/hwpe_stream_parity_checker_pkg.sv
// Shared definitions for the HWPE stream parity blocks.
// Covers the fault-cause bit positions and the cause vector type.
package hwpe_stream_parity_checker_pkg;

    localparam int unsigned CAUSE_VALID  = 0;
    localparam int unsigned CAUSE_STRB   = 1;
    localparam int unsigned CAUSE_PARITY = 2;

    typedef logic [2:0] fault_cause_t;

endpackage

// File: rtl/hwpe_stream_parity_checker_if.sv
// HWPE stream handshake bundle: valid/ready plus data and byte-lane strobe.
// The monitor modport only observes, for taps that must not disturb the stream.
interface hwpe_stream_parity_checker_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned STRB_WIDTH = DATA_WIDTH/8
) ();

    logic                  valid;
    logic                  ready;
    logic [DATA_WIDTH-1:0] data;
    logic [STRB_WIDTH-1:0] strb;

    modport master  (output valid, output data, output strb, input  ready);
    modport slave   (input  valid, input  data, input  strb, output ready);
    modport monitor (input  valid, input  data, input  strb, input  ready);

endinterface

// File: rtl/hwpe_stream_parity_checker.sv
// Consumer-side parity checker: compares a stream against its mirrored parity stream
// and keeps sticky fault status (causes, first faulty lanes, saturating fault count).
module hwpe_stream_parity_checker
    import hwpe_stream_parity_checker_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned STRB_WIDTH = DATA_WIDTH/8,
    parameter int unsigned CNT_WIDTH  = 8
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic                             clear_i,
    hwpe_stream_parity_checker_if.monitor    normal_i,
    hwpe_stream_parity_checker_if.slave      parity_i,
    output logic                             fault_detected_o,
    output logic                             fault_q_o,
    output logic                             fault_sticky_o,
    output fault_cause_t                     fault_cause_o,
    output logic [STRB_WIDTH-1:0]            fault_lanes_o,
    output logic [CNT_WIDTH-1:0]             fault_count_o
);

    localparam int unsigned LW = DATA_WIDTH/STRB_WIDTH;

    logic [STRB_WIDTH-1:0] exp_par;
    logic [STRB_WIDTH-1:0] lane_err;
    logic                  handshake;
    fault_cause_t          causes;

    logic                  fault_q_q, fault_q_d;
    logic                  sticky_q, sticky_d;
    fault_cause_t          cause_q, cause_d;
    logic [STRB_WIDTH-1:0] lanes_q, lanes_d;
    logic                  first_q, first_d;
    logic [CNT_WIDTH-1:0]  count_q, count_d;

    // The parity stream is terminated here, so it follows the real consumer's ready.
    assign parity_i.ready = normal_i.ready;

    assign handshake = normal_i.valid & normal_i.ready & parity_i.valid;

    for (genvar i = 0; i < STRB_WIDTH; i++) begin : gen_lane
        assign exp_par[i]  = ^normal_i.data[i*LW +: LW];
        assign lane_err[i] = handshake & normal_i.strb[i] & (exp_par[i] != parity_i.data[i]);
    end

    always_comb begin
        causes               = '0;
        causes[CAUSE_VALID]  = normal_i.valid != parity_i.valid;
        causes[CAUSE_STRB]   = normal_i.valid & parity_i.valid & (normal_i.strb != parity_i.strb);
        causes[CAUSE_PARITY] = |lane_err;
    end

    assign fault_detected_o = |causes;

    // Clear is applied first so a fault in the same cycle lands on top of the cleared state.
    always_comb begin
        fault_q_d = fault_detected_o;
        sticky_d  = sticky_q;
        cause_d   = cause_q;
        lanes_d   = lanes_q;
        first_d   = first_q;
        if (clear_i) begin
            sticky_d = 1'b0;
            cause_d  = '0;
            lanes_d  = '0;
            first_d  = 1'b0;
        end
        if (fault_detected_o) begin
            sticky_d = 1'b1;
            cause_d  = cause_d | causes;
            if (!first_d && (|lane_err)) begin
                lanes_d = lane_err;
                first_d = 1'b1;
            end
        end
    end

    always_comb begin
        count_d = clear_i ? '0 : count_q;
        if (fault_detected_o && (count_d != '1)) begin
            count_d = count_d + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fault_q_q <= 1'b0;
            sticky_q  <= 1'b0;
            cause_q   <= '0;
            lanes_q   <= '0;
            first_q   <= 1'b0;
        end else begin
            fault_q_q <= fault_q_d;
            sticky_q  <= sticky_d;
            cause_q   <= cause_d;
            lanes_q   <= lanes_d;
            first_q   <= first_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign fault_q_o      = fault_q_q;
    assign fault_sticky_o = sticky_q;
    assign fault_cause_o  = cause_q;
    assign fault_lanes_o  = lanes_q;
    assign fault_count_o  = count_q;

endmodule

// File: tb/tb_hwpe_stream_parity_checker.sv
// Directed bench for the stream parity checker, built with a 2-bit counter so
// saturation is reachable in a handful of cycles.
module tb_hwpe_stream_parity_checker;
    import hwpe_stream_parity_checker_pkg::*;

    localparam int unsigned DW = 32;
    localparam int unsigned SW = 4;
    localparam int unsigned CW = 2;

    logic          clk_i;
    logic          rst_ni;
    logic          clear_i;
    logic          fault_detected_o;
    logic          fault_q_o;
    logic          fault_sticky_o;
    fault_cause_t  fault_cause_o;
    logic [SW-1:0] fault_lanes_o;
    logic [CW-1:0] fault_count_o;

    int compared;
    int mismatched;

    hwpe_stream_parity_checker_if #(.DATA_WIDTH(DW), .STRB_WIDTH(SW)) normal_if ();
    hwpe_stream_parity_checker_if #(.DATA_WIDTH(SW), .STRB_WIDTH(SW)) parity_if ();

    hwpe_stream_parity_checker #(
        .DATA_WIDTH(DW),
        .STRB_WIDTH(SW),
        .CNT_WIDTH (CW)
    ) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .clear_i         (clear_i),
        .normal_i        (normal_if),
        .parity_i        (parity_if),
        .fault_detected_o(fault_detected_o),
        .fault_q_o       (fault_q_o),
        .fault_sticky_o  (fault_sticky_o),
        .fault_cause_o   (fault_cause_o),
        .fault_lanes_o   (fault_lanes_o),
        .fault_count_o   (fault_count_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Independent lane-parity reference used for the random clean traffic.
    function automatic logic [SW-1:0] calcPar(input logic [DW-1:0] d);
        logic [SW-1:0] p;
        p = '0;
        for (int l = 0; l < SW; l++) begin
            for (int b = 0; b < 8; b++) begin
                p[l] = p[l] ^ d[l*8 + b];
            end
        end
        return p;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic nv, input logic pv, input logic rdy,
                                 input logic [DW-1:0] nd, input logic [SW-1:0] ns,
                                 input logic [SW-1:0] pd, input logic [SW-1:0] ps,
                                 input logic clr);
        normal_if.valid = nv;
        normal_if.ready = rdy;
        normal_if.data  = nd;
        normal_if.strb  = ns;
        parity_if.valid = pv;
        parity_if.data  = pd;
        parity_if.strb  = ps;
        clear_i         = clr;
        #1;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 1'b0, 1'b1, '0, '0, '0, '0, 1'b0);
    endtask

    task automatic checkStatus(input string tag, input logic sticky, input logic [2:0] cause,
                               input logic [SW-1:0] lanes, input logic [CW-1:0] cnt);
        checkOutput({tag, "_sticky"}, 32'(fault_sticky_o), 32'(sticky));
        checkOutput({tag, "_cause"},  32'(fault_cause_o),  32'(cause));
        checkOutput({tag, "_lanes"},  32'(fault_lanes_o),  32'(lanes));
        checkOutput({tag, "_count"},  32'(fault_count_o),  32'(cnt));
    endtask

    initial begin
        logic [DW-1:0] rd;
        logic [SW-1:0] rs;
        logic          rv;
        logic          rr;

        compared   = 0;
        mismatched = 0;
        rst_ni     = 1'b0;
        idle();
        #2;
        checkOutput("reset_fault_q", 32'(fault_q_o), 32'd0);
        checkStatus("reset", 1'b0, 3'b000, 4'b0000, 2'd0);

        @(negedge clk_i);
        rst_ni = 1'b1;
        tick();

        // Clean traffic with random stalls and matching parity.
        for (int n = 0; n < 100; n++) begin
            rd = $urandom;
            rs = 4'($urandom_range(0, 15));
            rv = 1'($urandom_range(0, 1));
            rr = 1'($urandom_range(0, 1));
            applyStimulus(rv, rv, rr, rd, rs, calcPar(rd), rs, 1'b0);
            checkOutput("clean_detect", 32'(fault_detected_o), 32'd0);
            checkOutput("clean_ready", 32'(parity_if.ready), 32'(rr));
            tick();
        end
        checkOutput("clean_fault_q", 32'(fault_q_o), 32'd0);
        checkStatus("clean", 1'b0, 3'b000, 4'b0000, 2'd0);

        // Lane 2 parity flipped; bytes 11,0F,C3,A5 all have even parity.
        applyStimulus(1'b1, 1'b1, 1'b1, 32'hA5C3_0F11, 4'hF, 4'b0100, 4'hF, 1'b0);
        checkOutput("flip_detect", 32'(fault_detected_o), 32'd1);
        tick();
        idle();
        checkOutput("flip_fault_q", 32'(fault_q_o), 32'd1);
        checkStatus("flip", 1'b1, 3'b100, 4'b0100, 2'd1);
        tick();
        checkOutput("flip_q_drop", 32'(fault_q_o), 32'd0);
        checkOutput("flip_count_hold", 32'(fault_count_o), 32'd1);

        applyStimulus(1'b0, 1'b0, 1'b1, '0, '0, '0, '0, 1'b1);
        tick();
        idle();
        checkStatus("clear", 1'b0, 3'b000, 4'b0000, 2'd0);

        // Same flip on a disabled lane, then a bad parity beat while stalled.
        applyStimulus(1'b1, 1'b1, 1'b1, 32'hA5C3_0F11, 4'hB, 4'b0100, 4'hB, 1'b0);
        checkOutput("strb_off_detect", 32'(fault_detected_o), 32'd0);
        tick();
        applyStimulus(1'b1, 1'b1, 1'b0, 32'hA5C3_0F11, 4'hF, 4'b0001, 4'hF, 1'b0);
        checkOutput("stall_detect", 32'(fault_detected_o), 32'd0);
        tick();
        idle();
        checkStatus("no_fault", 1'b0, 3'b000, 4'b0000, 2'd0);

        // Missing parity beat for three cycles.
        for (int n = 0; n < 3; n++) begin
            applyStimulus(1'b1, 1'b0, 1'b1, 32'h0000_0001, 4'hF, 4'b0000, 4'hF, 1'b0);
            checkOutput("valid_detect", 32'(fault_detected_o), 32'd1);
            tick();
        end
        idle();
        checkStatus("valid", 1'b1, 3'b001, 4'b0000, 2'd3);

        applyStimulus(1'b0, 1'b0, 1'b1, '0, '0, '0, '0, 1'b1);
        tick();
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 4'hF, 4'b0000, 4'h7, 1'b0);
        checkOutput("strb_detect", 32'(fault_detected_o), 32'd1);
        tick();
        idle();
        checkStatus("strb", 1'b1, 3'b010, 4'b0000, 2'd1);

        // Saturation of the 2-bit counter.
        applyStimulus(1'b0, 1'b0, 1'b1, '0, '0, '0, '0, 1'b1);
        tick();
        for (int n = 0; n < 6; n++) begin
            applyStimulus(1'b0, 1'b1, 1'b1, '0, 4'hF, 4'b0000, 4'hF, 1'b0);
            tick();
            if (n == 2) checkOutput("sat_count_3", 32'(fault_count_o), 32'd3);
        end
        idle();
        checkStatus("sat", 1'b1, 3'b001, 4'b0000, 2'd3);

        // Clear together with a lane-0 parity fault keeps only this cycle's fault.
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h0000_0001, 4'hF, 4'b0000, 4'hF, 1'b1);
        checkOutput("clr_fault_detect", 32'(fault_detected_o), 32'd1);
        tick();
        idle();
        checkStatus("clr_fault", 1'b1, 3'b100, 4'b0001, 2'd1);

        // Later lane-3 parity fault must not overwrite the first captured lanes.
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h0100_0000, 4'hF, 4'b0000, 4'hF, 1'b0);
        tick();
        idle();
        checkStatus("second", 1'b1, 3'b100, 4'b0001, 2'd2);

        // Asynchronous reset mid-burst while a fault is active.
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h0, 4'hF, 4'b0000, 4'hF, 1'b0);
        tick();
        checkOutput("pre_rst_fault_q", 32'(fault_q_o), 32'd1);
        #1;
        rst_ni = 1'b0;
        #1;
        checkOutput("async_fault_q", 32'(fault_q_o), 32'd0);
        checkStatus("async", 1'b0, 3'b000, 4'b0000, 2'd0);
        idle();
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
